// File: rtl/mlp_sample_sequencer.sv
// Training driver for the MLP. It holds a small dataset, presents it sample by sample for a
// configured number of epochs with per-epoch learning-rate decay, then runs one inference pass
// and counts the samples whose thresholded predictions match their labels.
module mlp_sample_sequencer #(
  parameter int unsigned INPUTS      = 2,
  parameter int unsigned OUTPUTS     = 1,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned EVAL_SETTLE = 2,
  parameter int unsigned EPOCH_W     = 16,
  localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [IDX_W-1:0]   load_addr,
  input  real                load_values   [INPUTS],
  input  real                load_expected [OUTPUTS],
  input  logic [IDX_W:0]     num_samples,
  input  logic [EPOCH_W-1:0] num_epochs,
  input  real                lr_init,
  input  real                lr_decay,
  input  logic               start,
  input  real                prediction    [OUTPUTS],
  output real                values        [INPUTS],
  output real                expected      [OUTPUTS],
  output logic               training,
  output real                learning_rate,
  output logic [IDX_W-1:0]   sample_idx,
  output logic [EPOCH_W-1:0] epoch,
  output logic [IDX_W:0]     correct_count,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam int unsigned CW      = IDX_W + 1;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > EVAL_SETTLE) ? HOLD_CYCLES : EVAL_SETTLE;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {StIdle, StTrain, StEval, StDone} state_e;

  state_e             state_q, state_d;
  real                feat_q     [DEPTH][INPUTS];
  real                feat_d     [DEPTH][INPUTS];
  real                lbl_q      [DEPTH][OUTPUTS];
  real                lbl_d      [DEPTH][OUTPUTS];
  real                values_q   [INPUTS];
  real                values_d   [INPUTS];
  real                expected_q [OUTPUTS];
  real                expected_d [OUTPUTS];
  real                lr_q, lr_d;
  real                decay_q, decay_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] nepochs_q, nepochs_d;
  logic [CW-1:0]      nsamp_q, nsamp_d;
  logic [CW-1:0]      correct_q, correct_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               training_q, training_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               last_idx;
  logic               match;

  assign last_idx = (CW'(idx_q) + CW'(1)) == nsamp_q;

  // Thresholded comparison of the MLP output against the label currently presented.
  always_comb begin
    match = 1'b1;
    for (int k = 0; k < OUTPUTS; k++) begin
      if ((prediction[k] >= 0.5) != (expected_q[k] >= 0.5)) match = 1'b0;
    end
  end

  // Dataset writes, sequencing FSM and next values of all registered outputs.
  always_comb begin
    feat_d     = feat_q;
    lbl_d      = lbl_q;
    values_d   = values_q;
    expected_d = expected_q;
    state_d    = state_q;
    lr_d       = lr_q;
    decay_d    = decay_q;
    idx_d      = idx_q;
    epoch_d    = epoch_q;
    nepochs_d  = nepochs_q;
    nsamp_d    = nsamp_q;
    correct_d  = correct_q;
    cnt_d      = cnt_q;
    cfg_err_d  = 1'b0;

    // The write is applied to feat_d first so a same-cycle start presents the new data.
    if (load_valid && (state_q == StIdle || state_q == StDone) &&
        (CW'(load_addr) < CW'(DEPTH))) begin
      for (int i = 0; i < INPUTS; i++) feat_d[load_addr][i] = load_values[i];
      for (int k = 0; k < OUTPUTS; k++) lbl_d[load_addr][k] = load_expected[k];
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (num_samples == '0 || num_samples > CW'(DEPTH)) begin
            cfg_err_d = 1'b1;
          end else begin
            nsamp_d   = num_samples;
            nepochs_d = num_epochs;
            decay_d   = lr_decay;
            lr_d      = lr_init;
            idx_d     = '0;
            epoch_d   = '0;
            cnt_d     = '0;
            correct_d = '0;
            state_d   = (num_epochs != '0) ? StTrain : StEval;
          end
        end
      end
      StTrain: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d = '0;
          if (last_idx) begin
            idx_d = '0;
            // The final epoch hands over to eval without a trailing decay.
            if (epoch_q + EPOCH_W'(1) == nepochs_q) begin
              state_d = StEval;
            end else begin
              epoch_d = epoch_q + EPOCH_W'(1);
              lr_d    = lr_q * decay_q;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StEval: begin
        if (cnt_q == CNT_W'(EVAL_SETTLE - 1)) begin
          cnt_d = '0;
          if (match) correct_d = correct_q + CW'(1);
          if (last_idx) state_d = StDone;
          else          idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Present the selected slot while running; hold the last sample otherwise.
    if (state_d == StTrain || state_d == StEval) begin
      for (int i = 0; i < INPUTS; i++) values_d[i] = feat_d[idx_d][i];
      for (int k = 0; k < OUTPUTS; k++) expected_d[k] = lbl_d[idx_d][k];
    end

    training_d = (state_d == StTrain);
    busy_d     = (state_d == StTrain) || (state_d == StEval);
    done_d     = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      for (int d = 0; d < DEPTH; d++) begin
        for (int i = 0; i < INPUTS; i++) feat_q[d][i] <= 0.0;
        for (int k = 0; k < OUTPUTS; k++) lbl_q[d][k] <= 0.0;
      end
      for (int i = 0; i < INPUTS; i++) values_q[i] <= 0.0;
      for (int k = 0; k < OUTPUTS; k++) expected_q[k] <= 0.0;
      lr_q       <= 0.0;
      decay_q    <= 0.0;
      idx_q      <= '0;
      epoch_q    <= '0;
      nepochs_q  <= '0;
      nsamp_q    <= '0;
      correct_q  <= '0;
      cnt_q      <= '0;
      training_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      feat_q     <= feat_d;
      lbl_q      <= lbl_d;
      values_q   <= values_d;
      expected_q <= expected_d;
      lr_q       <= lr_d;
      decay_q    <= decay_d;
      idx_q      <= idx_d;
      epoch_q    <= epoch_d;
      nepochs_q  <= nepochs_d;
      nsamp_q    <= nsamp_d;
      correct_q  <= correct_d;
      cnt_q      <= cnt_d;
      training_q <= training_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign values        = values_q;
  assign expected      = expected_q;
  assign training      = training_q;
  assign learning_rate = lr_q;
  assign sample_idx    = idx_q;
  assign epoch         = epoch_q;
  assign correct_count = correct_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;

endmodule
